// File: rtl/fifo_arbiter_pkg.sv
// fifo_arb_defs: shared state encoding and width helper for fifo_arbiter
package fifo_arb_defs;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_arbiter_rr_picker.sv
// rr_picker: first eligible index at or after i_ptr, wrapping modulo NUM_REQ
module rr_picker
  import fifo_arb_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_pick,
  output logic               o_found
);
  logic [NUM_REQ-1:0] w_rot;
  logic [PTR_W-1:0]   w_off;
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_rot
    logic [PTR_W-1:0] w_idx;
    assign w_idx    = PTR_W'((int'(i_ptr) + j) % NUM_REQ);
    assign w_rot[j] = i_elig[w_idx];
  end
  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (w_rot[j]) w_off = PTR_W'(j);
    o_pick  = PTR_W'((int'(i_ptr) + int'(w_off)) % NUM_REQ);
    o_found = |i_elig;
  end
endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin burst arbiter merging NUM_REQ valid/ready streams
// into one FIFO producer port, holding each grant for at most MAX_BURST beats.
module fifo_arbiter
  import fifo_arb_defs::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_in,
  input  logic [NUM_REQ-1:0]            reqValid_in,
  output logic [NUM_REQ-1:0]            reqReady_out,
  input  logic [NUM_REQ-1:0]            enable_in,
  output logic [DATA_WIDTH-1:0]         outData_out,
  output logic                          outValid_out,
  input  logic                          outReady_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [CNT_WIDTH-1:0]          burstCount_out,
  output logic                          busy_out
);
  localparam int PTR_W = clog2(NUM_REQ);
  state_t               r_state, w_state_nx;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nx, w_elig;
  logic [PTR_W-1:0]     r_gidx, w_gidx_nx, r_ptr, w_ptr_nx, w_pick;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic                 w_found, w_busy, w_valid, w_xfer, w_release;
  assign w_elig = reqValid_in & enable_in;
  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_found(w_found)
  );
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_gidx  <= w_gidx_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  assign w_busy    = r_state == ST_BURST;
  assign w_valid   = w_busy & reqValid_in[r_gidx] & enable_in[r_gidx];
  assign w_xfer    = w_valid & outReady_in;
  // a dry or disabled source gives up the grant; a stalled one keeps it
  assign w_release = w_busy & (!reqValid_in[r_gidx] | !enable_in[r_gidx] |
                               (w_xfer & (r_cnt == CNT_WIDTH'(MAX_BURST - 1))));
  always_comb begin
    w_state_nx = w_release ? ST_IDLE : (w_busy | w_found) ? ST_BURST : ST_IDLE;
    w_grant_nx = w_release ? '0 : w_busy ? r_grant : w_found ? NUM_REQ'(1) << w_pick : '0;
    w_gidx_nx  = w_busy ? r_gidx : w_pick;
    w_ptr_nx   = w_release ? (r_gidx == PTR_W'(NUM_REQ - 1) ? '0 : r_gidx + 1'b1) : r_ptr;
    w_cnt_nx   = (w_busy & !w_release) ? r_cnt + CNT_WIDTH'(w_xfer) : '0;
  end
  always_comb begin
    outData_out    = w_busy ? reqData_in[r_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    outValid_out   = w_valid;
    reqReady_out   = (w_busy & outReady_in & enable_in[r_gidx]) ? NUM_REQ'(1) << r_gidx : '0;
    grant_out      = r_grant;
    burstCount_out = r_cnt;
    busy_out       = w_busy;
  end
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed scenarios for fifo_arbiter with NUM_REQ=4, MAX_BURST=4
module tb_fifo_arbiter;
  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [31:0] reqData_in;
  logic [3:0]  reqValid_in = '0;
  logic [3:0]  reqReady_out;
  logic [3:0]  enable_in = 4'b1111;
  logic [7:0]  outData_out;
  logic        outValid_out;
  logic        outReady_in = 1'b1;
  logic [3:0]  grant_out;
  logic [7:0]  burstCount_out;
  logic        busy_out;
  logic [7:0]  src_cnt [4];
  int          runs = 0;
  int          fails = 0;

  fifo_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(8)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .reqData_in(reqData_in),
    .reqValid_in(reqValid_in), .reqReady_out(reqReady_out), .enable_in(enable_in),
    .outData_out(outData_out), .outValid_out(outValid_out), .outReady_in(outReady_in),
    .grant_out(grant_out), .burstCount_out(burstCount_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // sources: requester i presents i*0x40 + beats it has had accepted
  always @(posedge clk_in or negedge reset_in)
    if (!reset_in) for (int i = 0; i < 4; i++) src_cnt[i] <= '0;
    else for (int i = 0; i < 4; i++) if (reqValid_in[i] && reqReady_out[i]) src_cnt[i] <= src_cnt[i] + 8'd1;

  always_comb begin
    reqData_in = '0;
    for (int i = 0; i < 4; i++) reqData_in[i*8 +: 8] = 8'(i * 64) + src_cnt[i];
  end

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b0; reqValid_in = '0; outReady_in = 1'b1; enable_in = 4'b1111;
    @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] got;
    reset_in = 1'b0; reqValid_in = 4'b1111; enable_in = 4'b1111; outReady_in = 1'b1;
    repeat (2) @(negedge clk_in);
    got = {grant_out, outValid_out, reqReady_out, busy_out, burstCount_out, outData_out};
    runs++;
    if (got !== '0) begin fails++; $display("FAIL reset got=%h exp=0", got); end
  endtask

  task automatic test_single();
    logic [24:0] got, exp;
    int p, b;
    do_reset(); reqValid_in = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in);
      p = c % 5; b = (c / 5) * 4 + p - 1;
      exp = (p == 0) ? '0 : {4'b0001, 1'b1, 8'(p - 1), 8'(b), 4'b0001};
      got = {grant_out, outValid_out, burstCount_out, outData_out, reqReady_out};
      runs++;
      if (got !== exp) begin fails++; $display("FAIL single c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_all_valid();
    logic [21:0] got, exp;
    int r, p;
    do_reset(); reqValid_in = 4'b1111;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_in);
      r = (c - 1) / 5; p = (c - 1) % 5;
      exp = (p == 4) ? '0 : {4'(1) << (r % 4), 1'b1, 1'b1, 8'(p), 8'((r % 4) * 64 + (r / 4) * 4 + p)};
      got = {grant_out, outValid_out, busy_out, burstCount_out, outData_out};
      runs++;
      if (got !== exp) begin fails++; $display("FAIL all_valid c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] got, exp;
    int n;
    do_reset(); reqValid_in = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_in);
      n = (c <= 3) ? c - 1 : (c <= 6) ? 2 : 3;
      exp = (c == 8) ? '0 : {4'b0010, 1'b1, 8'(n), 8'(64 + n), (c >= 4 && c <= 6) ? 4'b0000 : 4'b0010};
      got = {grant_out, outValid_out, burstCount_out, outData_out, reqReady_out};
      runs++;
      if (got !== exp) begin fails++; $display("FAIL backpressure c=%0d got=%h exp=%h", c, got, exp); end
      if (c == 3) outReady_in = 1'b0;
      if (c == 6) outReady_in = 1'b1;
    end
  endtask

  task automatic test_dry_release();
    logic [25:0] got, exp;
    do_reset(); reqValid_in = 4'b1100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      exp = (c <= 3) ? {4'b0100, 1'b1, 1'b1, 8'(c - 1), 8'(128 + c - 1), 4'b0100}
          : (c == 4) ? '0 : {4'b1000, 1'b1, 1'b1, 8'd0, 8'hC0, 4'b1000};
      got = {grant_out, outValid_out, busy_out, burstCount_out, outData_out, reqReady_out};
      runs++;
      if (got !== exp) begin fails++; $display("FAIL dry_release c=%0d got=%h exp=%h", c, got, exp); end
      if (c == 3) reqValid_in = 4'b1001;
    end
  endtask

  task automatic test_enable_mask();
    logic [12:0] got, exp;
    int seq [4] = '{0, 2, 3, 0};
    int r, p;
    do_reset(); reqValid_in = 4'b1111; enable_in = 4'b1101;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      r = (c - 1) / 5; p = (c - 1) % 5;
      exp = (p == 4) ? '0 : {4'(1) << seq[r], 1'b0, 8'(seq[r] * 64 + ((r == 3) ? 4 : 0) + p)};
      got = {grant_out, reqReady_out[1], outData_out};
      runs++;
      if (got !== exp) begin fails++; $display("FAIL enable_mask c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] got;
    logic [19:0] g2;
    do_reset(); reqValid_in = 4'b1111;
    repeat (7) @(negedge clk_in);
    runs++;
    if (grant_out !== 4'b0010) begin fails++; $display("FAIL async_pre got=%b exp=0010", grant_out); end
    #2 reset_in = 1'b0;
    #1 got = {grant_out, outValid_out, reqReady_out, busy_out, burstCount_out};
    runs++;
    if (got !== '0) begin fails++; $display("FAIL async_mid got=%h exp=0", got); end
    @(negedge clk_in); reset_in = 1'b1;
    @(negedge clk_in);
    g2 = {grant_out, burstCount_out, outData_out};
    runs++;
    if (g2 !== {4'b0001, 8'd0, 8'd0}) begin fails++; $display("FAIL async_post got=%h exp=10000", g2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_dry_release();
    test_enable_mask();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
